csr_trap_ctrl: RTL and testbench

//  Sequencer that owns the single CSR-file port (we/addr/wdata in, combinational rdata out).

---
 rtl/csr_pkg.sv | 34 +++
 rtl/csr_trap_ctrl_if.sv | 60 ++++++
 rtl/csr_alu.sv | 46 ++++
 rtl/csr_trap_ctrl.sv | 164 ++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants and types for the CSR trap sequencer
//
// Purpose: machine-mode CSR addresses used by trap entry/return, the
//          pipeline CSR op encodings, the sequencer state enum and the
//          pending-redirect kind.
// Ports:   none (package)
package csr_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T_EPC   = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_TVAL  = 3'd3,
    S_REDIR   = 3'd4
  } state_e;

  typedef enum logic {
    K_TRAP = 1'b0,
    K_MRET = 1'b1
  } kind_e;

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// rtl/csr_trap_ctrl_if.sv - request/response and CSR-file port bundle
//
// Purpose: groups the pipeline instruction port, trap and MRET handshakes,
//          the redirect strobe and the CSR-file port of csr_trap_ctrl.
// Modports:
//   slave  - the sequencer (csr_trap_ctrl)
//   master - the surrounding pipeline + csr_file
interface csr_trap_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
);

  logic              ins_valid;
  logic [1:0]        ins_op;
  logic [ADDR_W-1:0] ins_addr;
  logic [XLEN-1:0]   ins_src;
  logic              ins_ready;
  logic [XLEN-1:0]   ins_rdata;

  logic              trap_valid;
  logic [XLEN-1:0]   trap_pc;
  logic [XLEN-1:0]   trap_cause;
  logic [XLEN-1:0]   trap_tval;
  logic              trap_ready;

  logic              mret_valid;
  logic              mret_ready;

  logic              redir_valid;
  logic [XLEN-1:0]   redir_pc;
  logic              busy;

  logic              csr_we;
  logic [ADDR_W-1:0] csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   csr_rdata;
  logic [XLEN-1:0]   csr_mtvec;
  logic [XLEN-1:0]   csr_mepc;

  modport slave (
    input  ins_valid, ins_op, ins_addr, ins_src,
    input  trap_valid, trap_pc, trap_cause, trap_tval,
    input  mret_valid,
    input  csr_rdata, csr_mtvec, csr_mepc,
    output ins_ready, ins_rdata, trap_ready, mret_ready,
    output redir_valid, redir_pc, busy,
    output csr_we, csr_addr, csr_wdata
  );

  modport master (
    output ins_valid, ins_op, ins_addr, ins_src,
    output trap_valid, trap_pc, trap_cause, trap_tval,
    output mret_valid,
    output csr_rdata, csr_mtvec, csr_mepc,
    input  ins_ready, ins_rdata, trap_ready, mret_ready,
    input  redir_valid, redir_pc, busy,
    input  csr_we, csr_addr, csr_wdata
  );

endinterface

// File: rtl/csr_alu.sv
// rtl/csr_alu.sv - new-value and write-suppress logic for CSR instructions
//
// Purpose: combinational CSRRW/CSRRS/CSRRC update.
// Ports:
//   op    in   csr op (read-only, RW, RS, RC)
//   src   in   rs1/uimm operand
//   rdata in   current CSR value
//   wdata out  value to write back
//   we    out  1 when the instruction really writes the CSR
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e         op,
  input  logic [XLEN-1:0] src,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic            we
);

  always_comb begin
    wdata = rdata;
    we    = 1'b0;
    unique case (op)
      OP_RW: begin
        wdata = src;
        we    = 1'b1;
      end
      // Set/clear with a zero mask is architecturally a pure read.
      OP_RS: begin
        wdata = rdata | src;
        we    = |src;
      end
      OP_RC: begin
        wdata = rdata & ~src;
        we    = |src;
      end
      default: begin
        wdata = rdata;
        we    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - sequencer owning the single CSR-file port
//
// Purpose: arbitrates trap entry, MRET and pipeline CSR instructions onto
//          one CSR-file port. Trap entry writes mepc, mcause, (mtval) on
//          consecutive cycles, then strobes a redirect to mtvec; MRET
//          strobes a redirect to mepc the cycle after acceptance.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    csr_trap_ctrl_if.slave (ins/trap/mret handshakes, redirect,
//          busy, CSR-file we/addr/wdata/rdata and mtvec/mepc taps)
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 12,
  parameter bit HAS_TVAL = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  csr_trap_ctrl_if.slave bus
);

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [XLEN-1:0] pc_q, cause_q, tval_q;
  logic            trap_acc;
  logic            ins_sel;
  logic [XLEN-1:0] alu_wdata;
  logic            alu_we;

  // Redirect targets are word aligned: the mode bits of mtvec and the low
  // bits of mepc/trap_pc are intentionally dropped.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.csr_mtvec[1:0], bus.csr_mepc[1:0], bus.trap_pc[1:0]};

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op    (csr_op_e'(bus.ins_op)),
    .src   (bus.ins_src),
    .rdata (bus.csr_rdata),
    .wdata (alu_wdata),
    .we    (alu_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= K_TRAP;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      if (trap_acc) begin
        pc_q    <= {bus.trap_pc[XLEN-1:2], 2'b00};
        cause_q <= bus.trap_cause;
        tval_q  <= bus.trap_tval;
      end
    end
  end

  // Next state, handshakes, redirect and CSR address. Kept free of
  // csr_rdata so the combinational read path through csr_file cannot
  // close a loop back into this block.
  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    trap_acc        = 1'b0;
    ins_sel         = 1'b0;
    bus.ins_ready   = 1'b0;
    bus.trap_ready  = 1'b0;
    bus.mret_ready  = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;
    bus.busy        = (state_q != S_IDLE);
    bus.csr_addr    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.trap_valid) begin
          bus.trap_ready = 1'b1;
          trap_acc       = 1'b1;
          kind_d         = K_TRAP;
          state_d        = S_T_EPC;
        end else if (bus.mret_valid) begin
          bus.mret_ready = 1'b1;
          kind_d         = K_MRET;
          state_d        = S_REDIR;
        end else if (bus.ins_valid) begin
          bus.ins_ready  = 1'b1;
          ins_sel        = 1'b1;
          bus.csr_addr   = bus.ins_addr;
        end
      end
      S_T_EPC: begin
        bus.csr_addr = ADDR_W'(CSR_MEPC);
        state_d      = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        bus.csr_addr = ADDR_W'(CSR_MCAUSE);
        state_d      = HAS_TVAL ? S_T_TVAL : S_REDIR;
      end
      S_T_TVAL: begin
        bus.csr_addr = ADDR_W'(CSR_MTVAL);
        state_d      = S_REDIR;
      end
      S_REDIR: begin
        bus.redir_valid = 1'b1;
        bus.redir_pc    = (kind_q == K_MRET) ? {bus.csr_mepc[XLEN-1:2], 2'b00}
                                             : {bus.csr_mtvec[XLEN-1:2], 2'b00};
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // While reset is held every request is ignored and the port is quiet.
    if (!rst_n) begin
      state_d         = S_IDLE;
      trap_acc        = 1'b0;
      ins_sel         = 1'b0;
      bus.ins_ready   = 1'b0;
      bus.trap_ready  = 1'b0;
      bus.mret_ready  = 1'b0;
      bus.redir_valid = 1'b0;
      bus.redir_pc    = '0;
      bus.busy        = 1'b0;
      bus.csr_addr    = '0;
    end
  end

  // Write enable/data and instruction read-back.
  always_comb begin
    bus.csr_we    = 1'b0;
    bus.csr_wdata = '0;
    bus.ins_rdata = '0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (ins_sel) begin
            bus.csr_we    = alu_we;
            bus.csr_wdata = alu_wdata;
            bus.ins_rdata = bus.csr_rdata;
          end
        end
        S_T_EPC: begin
          bus.csr_we    = 1'b1;
          bus.csr_wdata = pc_q;
        end
        S_T_CAUSE: begin
          bus.csr_we    = 1'b1;
          bus.csr_wdata = cause_q;
        end
        S_T_TVAL: begin
          bus.csr_we    = 1'b1;
          bus.csr_wdata = tval_q;
        end
        default: begin
          bus.csr_we    = 1'b0;
          bus.csr_wdata = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - self-checking bench for csr_trap_ctrl
module tb_csr_trap_ctrl;
  import csr_pkg::*;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_trap_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();
  csr_trap_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus2 ();

  csr_trap_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .HAS_TVAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  csr_trap_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .HAS_TVAL(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // CSR file environment for each instance
  logic [31:0] mem  [4096];
  logic [31:0] mem2 [4096];
  logic pw, pw2;
  logic [11:0] pa, pa2;
  logic [31:0] pd, pd2;

  assign bus.csr_rdata  = mem[bus.csr_addr];
  assign bus.csr_mtvec  = mem[12'h305];
  assign bus.csr_mepc   = mem[12'h341];
  assign bus2.csr_rdata = mem2[bus2.csr_addr];
  assign bus2.csr_mtvec = mem2[12'h305];
  assign bus2.csr_mepc  = mem2[12'h341];

  always @(negedge clk) begin
    pw = bus.csr_we;   pa = bus.csr_addr;   pd = bus.csr_wdata;
    pw2 = bus2.csr_we; pa2 = bus2.csr_addr; pd2 = bus2.csr_wdata;
  end
  always @(posedge clk) begin
    if (pw === 1'b1) mem[pa] = pd;
    if (pw2 === 1'b1) mem2[pa2] = pd2;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- table of zero-latency CSR instructions ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] src;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;
  vec_t vecs [8];

  // ---------------- reference model for the random run ----------------
  // flags = {ins_ready, trap_ready, mret_ready, redir_valid, busy, csr_we}
  typedef struct {
    logic [5:0]  flags;
    logic        chk_addr;
    logic [11:0] addr;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        chk_pc;
    logic [31:0] pc;
    int          drop;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] ref_mem [logic [11:0]];
  logic [11:0] addr_tbl [7];

  function automatic exp_t mk(input logic [5:0] f);
    exp_t e;
    e.flags = f; e.chk_addr = 1'b0; e.addr = '0; e.chk_wdata = 1'b0; e.wdata = '0;
    e.chk_rdata = 1'b0; e.rdata = '0; e.chk_pc = 1'b0; e.pc = '0; e.drop = 0;
    return e;
  endfunction

  function automatic exp_t mk_wr(input logic [11:0] a, input logic [31:0] d);
    exp_t e = mk(6'b000011);
    e.chk_addr = 1'b1; e.addr = a; e.chk_wdata = 1'b1; e.wdata = d;
    return e;
  endfunction

  function automatic exp_t mk_redir(input logic [31:0] target);
    exp_t e = mk(6'b000110);
    e.chk_pc = 1'b1; e.pc = target & 32'hFFFF_FFFC;
    return e;
  endfunction

  task automatic clear_reqs();
    bus.trap_valid = 1'b0; bus.mret_valid = 1'b0; bus.ins_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old, nv, kept;
    logic tv, mv, iv, w;
    exp_t e;
    int c;

    vecs[0] = '{2'b10, 32'h80,   32'h8,    1'b1, 32'h88};
    vecs[1] = '{2'b11, 32'h0,    32'h88,   1'b0, 32'h0};
    vecs[2] = '{2'b11, 32'h8,    32'h88,   1'b1, 32'h80};
    vecs[3] = '{2'b01, 32'h1234, 32'h80,   1'b1, 32'h1234};
    vecs[4] = '{2'b00, 32'hFFFF, 32'h1234, 1'b0, 32'h0};
    vecs[5] = '{2'b10, 32'h0,    32'h1234, 1'b0, 32'h0};
    vecs[6] = '{2'b01, 32'h0,    32'h1234, 1'b1, 32'h0};
    vecs[7] = '{2'b00, 32'h5,    32'h0,    1'b0, 32'h0};

    addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};

    mem[12'h300] = 32'h8; mem[12'h305] = 32'h101; mem[12'h341] = 32'h0;
    mem[12'h342] = 32'h0; mem[12'h343] = 32'h0;
    mem2[12'h305] = 32'h203; mem2[12'h341] = 32'h0; mem2[12'h342] = 32'h0; mem2[12'h343] = 32'h0;

    bus2.trap_valid = 1'b0; bus2.mret_valid = 1'b0; bus2.ins_valid = 1'b0;
    bus2.ins_op = 2'b00; bus2.ins_addr = '0; bus2.ins_src = '0;
    bus2.trap_pc = '0; bus2.trap_cause = '0; bus2.trap_tval = '0;

    // ---- reset with every request raised ----
    bus.trap_valid = 1'b1; bus.trap_pc = 32'h1006; bus.trap_cause = 32'h2; bus.trap_tval = 32'hDEAD;
    bus.mret_valid = 1'b1;
    bus.ins_valid = 1'b1; bus.ins_op = 2'b00; bus.ins_addr = 12'h300; bus.ins_src = 32'h0;
    smp();
    check("rst.csr_we", bus.csr_we, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.readys", {bus.ins_ready, bus.trap_ready, bus.mret_ready}, 0);
    check("rst.redir_valid", bus.redir_valid, 0);
    check("rst.csr_addr", bus.csr_addr, 0);
    check("rst.csr_wdata", bus.csr_wdata, 0);
    step();
    rst_n = 1'b1;

    // ---- all three raised: trap wins, then mret, then ins ----
    smp();
    check("arb.readys", {bus.ins_ready, bus.trap_ready, bus.mret_ready}, 3'b010);
    check("arb.csr_we", bus.csr_we, 0);
    check("arb.busy", bus.busy, 0);
    step();
    bus.trap_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("trap.we", bus.csr_we, 1);
      check("trap.addr", bus.csr_addr, (k == 0) ? 12'h341 : (k == 1) ? 12'h342 : 12'h343);
      check("trap.wdata", bus.csr_wdata, (k == 0) ? 32'h1004 : (k == 1) ? 32'h2 : 32'hDEAD);
      check("trap.busy", bus.busy, 1);
      check("trap.held_readys", {bus.ins_ready, bus.mret_ready, bus.redir_valid}, 0);
      step();
    end
    smp();
    check("trap.redir_valid", bus.redir_valid, 1);
    check("trap.redir_pc", bus.redir_pc, 32'h100);
    check("trap.redir_flags", {bus.busy, bus.csr_we, bus.ins_ready, bus.mret_ready}, 4'b1000);
    step();
    smp();
    check("held.mret_ready", {bus.mret_ready, bus.ins_ready, bus.busy}, 3'b100);
    step();
    bus.mret_valid = 1'b0;
    smp();
    check("held.mret_redir", {bus.redir_valid, bus.busy}, 2'b11);
    check("held.mret_pc", bus.redir_pc, 32'h1004);
    step();
    smp();
    check("held.ins_ready", bus.ins_ready, 1);
    check("held.ins_rdata", bus.ins_rdata, 32'h8);
    check("held.ins_we", bus.csr_we, 0);
    step();

    // ---- table of CSR ops at 0x300 ----
    for (int i = 0; i < 8; i++) begin
      bus.ins_valid = 1'b1; bus.ins_addr = 12'h300;
      bus.ins_op = vecs[i].op; bus.ins_src = vecs[i].src;
      smp();
      check($sformatf("tbl%0d.ready", i), {bus.ins_ready, bus.busy}, 2'b10);
      check($sformatf("tbl%0d.rdata", i), bus.ins_rdata, vecs[i].exp_rdata);
      check($sformatf("tbl%0d.we", i), bus.csr_we, vecs[i].exp_we);
      check($sformatf("tbl%0d.addr", i), bus.csr_addr, 12'h300);
      if (vecs[i].exp_we) check($sformatf("tbl%0d.wdata", i), bus.csr_wdata, vecs[i].exp_wdata);
      step();
    end
    bus.ins_valid = 1'b0;

    // ---- MRET to 0x2000 ----
    mem[12'h341] = 32'h2000;
    bus.mret_valid = 1'b1;
    smp();
    check("mret.accept", {bus.mret_ready, bus.redir_valid}, 2'b10);
    step();
    bus.mret_valid = 1'b0;
    smp();
    check("mret.redir_valid", bus.redir_valid, 1);
    check("mret.redir_pc", bus.redir_pc, 32'h2000);
    step();
    smp();
    check("mret.idle", {bus.redir_valid, bus.busy}, 0);
    step();

    // ---- HAS_TVAL=0 instance ----
    bus2.trap_valid = 1'b1; bus2.trap_pc = 32'h43; bus2.trap_cause = 32'h5; bus2.trap_tval = 32'h7;
    smp();
    check("notval.accept", bus2.trap_ready, 1);
    step();
    bus2.trap_valid = 1'b0;
    smp();
    check("notval.epc", {bus2.csr_we, bus2.csr_addr, bus2.csr_wdata}, {1'b1, 12'h341, 32'h40});
    step();
    smp();
    check("notval.cause", {bus2.csr_we, bus2.csr_addr, bus2.csr_wdata}, {1'b1, 12'h342, 32'h5});
    step();
    smp();
    check("notval.redir", {bus2.redir_valid, bus2.csr_we}, 2'b10);
    check("notval.redir_pc", bus2.redir_pc, 32'h200);
    step();
    smp();
    check("notval.idle", {bus2.redir_valid, bus2.busy}, 0);
    check("notval.no_mtval", mem2[12'h343], 32'h0);
    step();

    // ---- randomized run against the reference model ----
    foreach (addr_tbl[i]) begin
      old = $urandom;
      mem[addr_tbl[i]] = old;
      ref_mem[addr_tbl[i]] = old;
    end
    c = 0;
    while (c < 400 || exp_q.size() != 0) begin
      if (exp_q.size() == 0) begin
        tv = ($urandom_range(0, 5) == 0);
        mv = ($urandom_range(0, 4) == 0);
        iv = ($urandom_range(0, 2) != 0);
        bus.trap_valid = tv; bus.mret_valid = mv; bus.ins_valid = iv;
        bus.trap_pc = $urandom; bus.trap_cause = $urandom; bus.trap_tval = $urandom;
        bus.ins_op = 2'($urandom_range(0, 3));
        bus.ins_addr = addr_tbl[$urandom_range(0, 6)];
        bus.ins_src = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        if (tv) begin
          e = mk(6'b010000); e.drop = 1; exp_q.push_back(e);
          exp_q.push_back(mk_wr(12'h341, bus.trap_pc & 32'hFFFF_FFFC));
          exp_q.push_back(mk_wr(12'h342, bus.trap_cause));
          exp_q.push_back(mk_wr(12'h343, bus.trap_tval));
          exp_q.push_back(mk_redir(ref_mem[12'h305]));
        end else if (mv) begin
          e = mk(6'b001000); e.drop = 2; exp_q.push_back(e);
          exp_q.push_back(mk_redir(ref_mem[12'h341]));
        end else if (iv) begin
          old = ref_mem[bus.ins_addr];
          case (bus.ins_op)
            2'b01:   nv = bus.ins_src;
            2'b10:   nv = old | bus.ins_src;
            2'b11:   nv = old & ~bus.ins_src;
            default: nv = old;
          endcase
          w = (bus.ins_op == 2'b01) || (bus.ins_op != 2'b00 && bus.ins_src != 0);
          e = mk({1'b1, 4'b0000, w});
          e.chk_addr = 1'b1; e.addr = bus.ins_addr;
          e.chk_rdata = 1'b1; e.rdata = old;
          e.chk_wdata = w; e.wdata = nv;
          e.drop = 3;
          exp_q.push_back(e);
        end else begin
          exp_q.push_back(mk(6'b000000));
        end
      end
      e = exp_q.pop_front();
      smp();
      check("rnd.flags", {bus.ins_ready, bus.trap_ready, bus.mret_ready,
                          bus.redir_valid, bus.busy, bus.csr_we}, e.flags);
      if (e.chk_addr)  check("rnd.addr", bus.csr_addr, e.addr);
      if (e.chk_wdata) check("rnd.wdata", bus.csr_wdata, e.wdata);
      if (e.chk_rdata) check("rnd.rdata", bus.ins_rdata, e.rdata);
      if (e.chk_pc)    check("rnd.redir_pc", bus.redir_pc, e.pc);
      step();
      if (e.flags[0]) ref_mem[e.addr] = e.wdata;
      case (e.drop)
        1: bus.trap_valid = 1'b0;
        2: bus.mret_valid = 1'b0;
        3: bus.ins_valid = 1'b0;
        default: ;
      endcase
      c++;
    end
    clear_reqs();
    step();

    // ---- reset during T_CAUSE ----
    mem[12'h342] = 32'h99;
    kept = mem[12'h342];
    bus.trap_valid = 1'b1; bus.trap_pc = 32'h3000; bus.trap_cause = 32'h7; bus.trap_tval = 32'h55;
    smp();
    check("midrst.accept", bus.trap_ready, 1);
    step();
    bus.trap_valid = 1'b0;
    smp();
    check("midrst.epc", {bus.csr_we, bus.csr_addr}, {1'b1, 12'h341});
    step();
    rst_n = 1'b0;
    smp();
    check("midrst.in_reset", {bus.csr_we, bus.busy, bus.redir_valid}, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp();
      check("midrst.idle", {bus.busy, bus.redir_valid, bus.csr_we}, 0);
      step();
    end
    check("midrst.mepc_kept", mem[12'h341], 32'h3000);
    check("midrst.mcause_unwritten", mem[12'h342], kept);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
